// File: rtl/gmii_tx_framer_if.sv
// Stream-in / GMII-out bundle for the transmit framer.
// slave is the framer side; master is the packet source and GMII sink side.
interface gmii_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;

    modport master (
        output s_data, s_valid, s_last,
        input  s_ready, gmii_txd, gmii_tx_en, gmii_tx_er
    );

    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready, gmii_txd, gmii_tx_en, gmii_tx_er
    );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, zero pad, CRC-32 FCS and IPG.
// Slot contents are decided by the FSM and pass through two output registers.
module gmii_tx_framer #(
    parameter int unsigned PRE_LEN = 7,
    parameter int unsigned MIN_LEN = 60,
    parameter int unsigned IPG_LEN = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    gmii_tx_framer_if.slave   bus,
    output logic [15:0]       frame_count_o,
    output logic [15:0]       underrun_count_o
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_ERR, ST_DROP, ST_PAD, ST_FCS, ST_IPG
    } state_e;

    localparam logic [15:0] PRE_LAST = 16'(PRE_LEN - 1);
    localparam logic [15:0] IPG_LAST = 16'(IPG_LEN - 1);
    localparam logic [15:0] MIN_CNT  = 16'(MIN_LEN);

    state_e      state_q, state_d;
    logic [15:0] step_q, step_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic        miss_last_q, miss_last_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] under_cnt_q, under_cnt_d;
    logic [15:0] pay_inc_s;
    logic [31:0] crc_inv_s;
    logic [7:0]  fcs_byte_s;
    logic [7:0]  txd_s;
    logic        en_s, er_s;
    logic [7:0]  txd_p_q, txd_q;
    logic        en_p_q, en_q, er_p_q, er_q;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int b = 0; b < 8; b++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    assign pay_inc_s = (pay_cnt_q == 16'hFFFF) ? pay_cnt_q : pay_cnt_q + 16'd1;
    assign bus.s_ready = (state_q == ST_DATA) || (state_q == ST_DROP);
    assign bus.gmii_txd   = txd_q;
    assign bus.gmii_tx_en = en_q;
    assign bus.gmii_tx_er = er_q;
    assign frame_count_o    = frame_cnt_q;
    assign underrun_count_o = under_cnt_q;

    // Select the FCS byte, least significant byte of the inverted CRC first.
    always_comb begin
        crc_inv_s = ~crc_q;
        case (step_q[1:0])
            2'd0:    fcs_byte_s = crc_inv_s[7:0];
            2'd1:    fcs_byte_s = crc_inv_s[15:8];
            2'd2:    fcs_byte_s = crc_inv_s[23:16];
            default: fcs_byte_s = crc_inv_s[31:24];
        endcase
    end

    // Next-state and output-slot logic for the framing FSM.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        pay_cnt_d   = pay_cnt_q;
        crc_d       = crc_q;
        miss_last_d = miss_last_q;
        frame_cnt_d = frame_cnt_q;
        under_cnt_d = under_cnt_q;
        txd_s       = 8'h00;
        en_s        = 1'b0;
        er_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.s_valid) begin
                    state_d = ST_PRE;
                    step_d  = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                txd_s = 8'h55;
                en_s  = 1'b1;
                if (step_q == PRE_LAST) begin
                    state_d = ST_SFD;
                    step_d  = 16'd0;
                end else begin
                    step_d = step_q + 16'd1;
                end
            end
            ST_SFD: begin
                txd_s     = 8'hD5;
                en_s      = 1'b1;
                crc_d     = 32'hFFFF_FFFF;
                pay_cnt_d = 16'd0;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                if (bus.s_valid) begin
                    txd_s     = bus.s_data;
                    en_s      = 1'b1;
                    crc_d     = crc32_byte(crc_q, bus.s_data);
                    pay_cnt_d = pay_inc_s;
                    if (!bus.s_last) begin
                        state_d = ST_DATA;
                    end else if (pay_inc_s < MIN_CNT) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_FCS;
                        step_d  = 16'd0;
                    end
                end else begin
                    // The missing byte's slot carries the error marker so tx_en stays unbroken.
                    txd_s       = 8'h00;
                    en_s        = 1'b1;
                    er_s        = 1'b1;
                    miss_last_d = bus.s_last;
                    state_d     = ST_ERR;
                end
            end
            ST_ERR: begin
                under_cnt_d = under_cnt_q + 16'd1;
                step_d      = 16'd0;
                if (miss_last_q) begin
                    state_d = ST_IPG;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (bus.s_valid && bus.s_last) begin
                    state_d = ST_IPG;
                    step_d  = 16'd0;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_PAD: begin
                txd_s     = 8'h00;
                en_s      = 1'b1;
                crc_d     = crc32_byte(crc_q, 8'h00);
                pay_cnt_d = pay_inc_s;
                if (pay_inc_s >= MIN_CNT) begin
                    state_d = ST_FCS;
                    step_d  = 16'd0;
                end else begin
                    state_d = ST_PAD;
                end
            end
            ST_FCS: begin
                txd_s = fcs_byte_s;
                en_s  = 1'b1;
                if (step_q == 16'd3) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_IPG;
                    step_d      = 16'd0;
                end else begin
                    step_d = step_q + 16'd1;
                end
            end
            ST_IPG: begin
                if (step_q != IPG_LAST) begin
                    step_d = step_q + 16'd1;
                end else if (bus.s_valid) begin
                    state_d = ST_PRE;
                    step_d  = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = 16'd0;
            end
        endcase
    end

    // FSM state, payload counter, CRC and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= 16'd0;
            pay_cnt_q   <= 16'd0;
            crc_q       <= 32'hFFFF_FFFF;
            miss_last_q <= 1'b0;
            frame_cnt_q <= 16'd0;
            under_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            pay_cnt_q   <= pay_cnt_d;
            crc_q       <= crc_d;
            miss_last_q <= miss_last_d;
            frame_cnt_q <= frame_cnt_d;
            under_cnt_q <= under_cnt_d;
        end
    end

    // Two-stage output pipeline: an accepted byte reaches the pins one edge after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd_p_q <= 8'h00;
            en_p_q  <= 1'b0;
            er_p_q  <= 1'b0;
            txd_q   <= 8'h00;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
        end else begin
            txd_p_q <= txd_s;
            en_p_q  <= en_s;
            er_p_q  <= er_s;
            txd_q   <= txd_p_q;
            en_q    <= en_p_q;
            er_q    <= er_p_q;
        end
    end
endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: table vectors, corner sequences and random frames
// checked against a queue-based frame model with a bit-serial CRC-32.
module tb_gmii_tx_framer;
    logic clk = 1'b0;
    logic rst_n;
    always #4 clk = ~clk;

    gmii_tx_framer_if ifa();
    gmii_tx_framer_if ifb();
    logic [15:0] fc_a, uc_a, fc_b, uc_b;

    gmii_tx_framer #(.PRE_LEN(7), .MIN_LEN(60), .IPG_LEN(12)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
        .frame_count_o(fc_a), .underrun_count_o(uc_a));
    gmii_tx_framer #(.PRE_LEN(7), .MIN_LEN(0), .IPG_LEN(12)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave),
        .frame_count_o(fc_b), .underrun_count_o(uc_b));

    logic       sel;
    logic [7:0] drv_data;
    logic       drv_valid, drv_last;
    assign ifa.s_data  = drv_data;
    assign ifa.s_valid = drv_valid & ~sel;
    assign ifa.s_last  = drv_last;
    assign ifb.s_data  = drv_data;
    assign ifb.s_valid = drv_valid & sel;
    assign ifb.s_last  = drv_last;

    logic [7:0] m_txd;
    logic       m_en, m_er, m_ready;
    assign m_txd   = sel ? ifb.gmii_txd   : ifa.gmii_txd;
    assign m_en    = sel ? ifb.gmii_tx_en : ifa.gmii_tx_en;
    assign m_er    = sel ? ifb.gmii_tx_er : ifa.gmii_tx_er;
    assign m_ready = sel ? ifb.s_ready    : ifa.s_ready;

    int checks = 0;
    int failures = 0;
    int exp_fc_a = 0, exp_uc_a = 0, exp_fc_b = 0;
    logic [7:0] pl[$];
    logic [7:0] exp[$];
    logic [7:0] exp1[$];

    logic [7:0] all_bytes[$];
    int f_start[$], f_len[$], f_er[$], f_er_pos[$], gaps[$];
    bit cap_on = 1'b0, had_frame = 1'b0;
    int cur_start = 0, cur_len = 0, cur_er = 0, cur_er_pos = -1, gap_run = 0, er_stray = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reflected CRC-32 computed one bit at a time from the polynomial definition.
    function automatic logic [31:0] ref_fcs(input logic [7:0] q[$]);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    function automatic void build_exp(input int min_len);
        logic [7:0] body[$];
        logic [31:0] f;
        body = pl;
        while (body.size() < min_len) body.push_back(8'h00);
        exp.delete();
        for (int i = 0; i < 7; i++) exp.push_back(8'h55);
        exp.push_back(8'hD5);
        foreach (body[i]) exp.push_back(body[i]);
        f = ref_fcs(body);
        for (int k = 0; k < 4; k++) exp.push_back(f[8*k +: 8]);
    endfunction

    // Capture every tx_en burst as a frame and every tx_en-low run as a gap.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cap_on = 1'b0; had_frame = 1'b0; gap_run = 0;
            end else if (m_en) begin
                if (!cap_on) begin
                    cap_on = 1'b1; cur_start = all_bytes.size(); cur_len = 0;
                    cur_er = 0; cur_er_pos = -1;
                    if (had_frame) gaps.push_back(gap_run);
                end
                all_bytes.push_back(m_txd);
                if (m_er) begin cur_er++; cur_er_pos = cur_len; end
                cur_len++;
            end else begin
                if (cap_on) begin
                    cap_on = 1'b0; had_frame = 1'b1; gap_run = 0;
                    f_start.push_back(cur_start); f_len.push_back(cur_len);
                    f_er.push_back(cur_er); f_er_pos.push_back(cur_er_pos);
                end
                if (m_er) er_stray++;
                gap_run++;
            end
        end
    end

    task automatic send_frame(input int under_at, input bit hold);
        int i;
        int guard;
        bit acc;
        i = 0; guard = 0;
        drv_data = pl[0]; drv_last = (pl.size() == 1); drv_valid = 1'b1;
        while (i < pl.size() && guard < 4000) begin
            @(negedge clk); acc = m_ready;
            @(posedge clk); #1; guard++;
            if (acc) begin
                i++;
                if (i == under_at) begin
                    drv_valid = 1'b0; drv_last = 1'b0;
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                    drv_valid = 1'b1;
                end
                if (i < pl.size()) begin
                    drv_data = pl[i]; drv_last = (i == pl.size() - 1);
                end
            end
        end
        chk("send_accepted", i, pl.size());
        drv_last = 1'b0;
        if (!hold) drv_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        int quiet;
        int n;
        quiet = 0; n = 0;
        while (quiet < 20 && n < 3000) begin
            @(negedge clk); n++;
            if (m_en) quiet = 0; else quiet++;
        end
        chk("quiet_reached", quiet >= 20, 1);
    endtask

    task automatic compare_frame(input int idx, input string name);
        int s, len, bad;
        s = f_start[idx]; len = f_len[idx]; bad = 0;
        chk({name, "_len"}, len, exp.size());
        for (int k = 0; k < len && k < exp.size(); k++) if (all_bytes[s+k] !== exp[k]) bad++;
        chk({name, "_bytes_bad"}, bad, 0);
        chk({name, "_tx_er"}, f_er[idx], 0);
    endtask

    task automatic run_frame(input string name);
        int nf;
        nf = f_len.size();
        build_exp(sel ? 0 : 60);
        send_frame(0, 1'b0);
        wait_quiet();
        chk({name, "_nframes"}, f_len.size(), nf + 1);
        if (f_len.size() == nf + 1) compare_frame(nf, name);
        if (sel) exp_fc_b++; else exp_fc_a++;
        chk({name, "_frame_count"}, sel ? fc_b : fc_a, sel ? exp_fc_b : exp_fc_a);
    endtask

    typedef struct {
        int len;
        bit min0;
        int exp_en;
    } vec_t;
    vec_t vt[7];

    initial begin
        #800000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nf, n, s, last;
        logic [31:0] fcs;

        vt[0] = '{9, 1'b1, 21};
        vt[1] = '{64, 1'b0, 76};
        vt[2] = '{10, 1'b0, 72};
        vt[3] = '{1, 1'b0, 72};
        vt[4] = '{59, 1'b0, 72};
        vt[5] = '{60, 1'b0, 72};
        vt[6] = '{61, 1'b0, 73};

        sel = 1'b0; drv_data = 8'h00; drv_valid = 1'b0; drv_last = 1'b0;
        rst_n = 1'b0;
        #10;
        chk("rst_txd", ifa.gmii_txd, 0);
        chk("rst_tx_en", ifa.gmii_tx_en, 0);
        chk("rst_tx_er", ifa.gmii_tx_er, 0);
        chk("rst_s_ready", ifa.s_ready, 0);
        chk("rst_frame_count", fc_a, 0);
        chk("rst_underrun_count", uc_a, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;

        // Table vectors: length, padding and FCS boundaries.
        for (int v = 0; v < 7; v++) begin
            sel = vt[v].min0;
            pl.delete();
            for (int k = 0; k < vt[v].len; k++) pl.push_back(vt[v].min0 ? 8'(8'h31 + k) : 8'(k));
            run_frame("vec");
            last = f_len.size() - 1;
            if (last >= 0) chk("vec_en_cycles", f_len[last], vt[v].exp_en);
            if (v == 0 && last >= 0) begin
                s = f_start[last] + f_len[last];
                fcs = {all_bytes[s-1], all_bytes[s-2], all_bytes[s-3], all_bytes[s-4]};
                chk("t1_fcs_check_value", fcs, 32'hCBF4_3926);
            end
        end
        sel = 1'b0;

        // Back-to-back frames with s_valid held high.
        nf = f_len.size();
        pl.delete();
        for (int k = 0; k < 64; k++) pl.push_back(8'(k));
        build_exp(60); exp1 = exp;
        send_frame(0, 1'b1);
        pl.delete();
        for (int k = 0; k < 64; k++) pl.push_back(8'(8'hA0 + k));
        send_frame(0, 1'b0);
        wait_quiet();
        chk("b2b_nframes", f_len.size(), nf + 2);
        if (f_len.size() == nf + 2) begin
            chk("b2b_gap", gaps[gaps.size()-1], 12);
            build_exp(60);
            compare_frame(nf + 1, "b2b_second");
            exp = exp1;
            compare_frame(nf, "b2b_first");
        end
        exp_fc_a += 2;
        chk("b2b_frame_count", fc_a, exp_fc_a);

        // Underrun after byte 5 of 20, then a normal frame.
        nf = f_len.size();
        pl.delete();
        for (int k = 0; k < 20; k++) pl.push_back(8'(8'h40 + k));
        build_exp(60);
        send_frame(5, 1'b0);
        wait_quiet();
        chk("urun_nframes", f_len.size(), nf + 1);
        if (f_len.size() == nf + 1) begin
            chk("urun_len", f_len[nf], 14);
            chk("urun_er_cycles", f_er[nf], 1);
            chk("urun_er_pos", f_er_pos[nf], 13);
            n = 0;
            for (int k = 0; k < 13 && k < f_len[nf]; k++) if (all_bytes[f_start[nf]+k] !== exp[k]) n++;
            chk("urun_prefix_bad", n, 0);
            chk("urun_err_txd", all_bytes[f_start[nf]+13], 0);
        end
        exp_uc_a++;
        chk("urun_underrun_count", uc_a, exp_uc_a);
        chk("urun_frame_count", fc_a, exp_fc_a);
        pl.delete();
        for (int k = 0; k < 12; k++) pl.push_back(8'(8'hC0 + k));
        run_frame("after_urun");

        // Reset asserted while the framer is in DATA.
        pl.delete();
        for (int k = 0; k < 30; k++) pl.push_back(8'(k));
        drv_data = pl[0]; drv_last = 1'b0; drv_valid = 1'b1;
        n = 0;
        while (!m_ready && n < 200) begin @(negedge clk); n++; end
        chk("t6_reach_data", m_ready, 1);
        repeat (3) @(posedge clk);
        #2;
        chk("t6_en_before_reset", m_en, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_txd", ifa.gmii_txd, 0);
        chk("t6_tx_en", ifa.gmii_tx_en, 0);
        chk("t6_tx_er", ifa.gmii_tx_er, 0);
        chk("t6_s_ready", ifa.s_ready, 0);
        chk("t6_frame_count", fc_a, 0);
        drv_valid = 1'b0;
        exp_fc_a = 0; exp_uc_a = 0; exp_fc_b = 0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        pl.delete();
        for (int k = 0; k < 15; k++) pl.push_back(8'(8'h70 + k));
        run_frame("after_reset");

        // Random frames on both instances against the model.
        for (int r = 0; r < 10; r++) begin
            sel = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 80);
            pl.delete();
            for (int k = 0; k < n; k++) pl.push_back(8'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_frame("rand");
        end
        sel = 1'b0;

        chk("stray_tx_er", er_stray, 0);
        chk("final_underrun_count", uc_a, exp_uc_a);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
